// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its memory-wait FSM.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StErr  = 2'd2
    } mem_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipe_ctrl_dmem_wait_fsm.sv
// Data-memory req/ack sequencer with a timeout that parks the FSM in a terminal error state.
module dmem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_valid_i,
    input  logic       ack_i,
    output mem_state_t state_o,
    output logic       req_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned TimerW = $clog2(MEM_TIMEOUT);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(MEM_TIMEOUT - 1);

    mem_state_t        state_q;
    logic [TimerW-1:0] timer_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    if (mem_valid_i) state_q <= StReq;
                end
                StReq: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (ack_i) begin
                        state_q <= StIdle;
                    end else if (timer_q == TimerMax) begin
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign state_o = state_q;
    assign req_o   = rst && (state_q == StReq);
    assign done_o  = (state_q == StReq) && ack_i;
    assign err_o   = (state_q == StErr);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables/flushes from memory freeze, taken branches and load-use
// hazards, plus stall and flush event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_rs1_use,
    input  logic             d_rs2_use,
    input  logic [4:0]       e_rd,
    input  logic             e_is_load,
    input  logic             e_br_taken,
    input  logic             m_mem_valid,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             reg_d_en,
    output logic             reg_e_en,
    output logic             reg_m_en,
    output logic             reg_d_flush,
    output logic             reg_e_flush,
    output logic             reg_w_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    mem_state_t mem_state;
    logic       mem_done;
    logic       freeze;
    logic       load_use;

    dmem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_dmem_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_valid_i(m_mem_valid),
        .ack_i      (dmem_ack),
        .state_o    (mem_state),
        .req_o      (dmem_req),
        .done_o     (mem_done),
        .err_o      (mem_err)
    );

    assign freeze   = (m_mem_valid && !mem_done) || (mem_state == StErr);
    assign load_use = e_is_load && (e_rd != REG_X0) &&
                      ((d_rs1_use && (d_rs1 == e_rd)) || (d_rs2_use && (d_rs2 == e_rd)));

    always_comb begin
        pc_en       = 1'b0;
        reg_d_en    = 1'b0;
        reg_e_en    = 1'b0;
        reg_m_en    = 1'b0;
        reg_d_flush = 1'b0;
        reg_e_flush = 1'b0;
        reg_w_flush = 1'b0;
        if (rst) begin
            if (freeze) begin
                // W takes a bubble so the held M instruction does not write back twice.
                reg_w_flush = 1'b1;
            end else if (e_br_taken) begin
                pc_en       = 1'b1;
                reg_d_en    = 1'b1;
                reg_e_en    = 1'b1;
                reg_m_en    = 1'b1;
                reg_d_flush = 1'b1;
                reg_e_flush = 1'b1;
            end else if (load_use) begin
                reg_e_en    = 1'b1;
                reg_e_flush = 1'b1;
                reg_m_en    = 1'b1;
            end else begin
                pc_en    = 1'b1;
                reg_d_en = 1'b1;
                reg_e_en = 1'b1;
                reg_m_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze || (load_use && !e_br_taken)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (e_br_taken && !freeze) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
